// File: rtl/decode_sched_pkg.sv
// Shared types and default latencies for the decode-stage issue scheduler.
package decode_sched_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  typedef logic [2:0] reg_idx_t;
  typedef logic [2:0] cnt_t;

  localparam int NREGS       = 8;
  localparam int ALU_LAT_DEF = 3;
  localparam int LD_LAT_DEF  = 4;

endpackage

// File: rtl/decode_sched_sb_entry.sv
// One scoreboard entry: writeback countdown plus the busy decision for readers.
// With DECODE_SCHED_FWD_EN defined, a writer-type bit relaxes busy to the forwarding window.
module sb_entry
  import decode_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ld,
  input  cnt_t ld_val,
  input  logic ld_is_load,
  output cnt_t cnt,
  output logic busy
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 3'd1;
    end
  end

`ifdef DECODE_SCHED_FWD_EN
  logic is_ld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_ld <= 1'b0;
    end else if (ld) begin
      is_ld <= ld_is_load;
    end
  end

  // Load results forward one cycle later than ALU results.
  assign busy = is_ld ? (cnt > 3'd1) : (cnt > 3'd2);
`else
  logic unused_is_load;

  assign unused_is_load = ld_is_load;
  assign busy           = (cnt != '0);
`endif

endmodule

// File: rtl/decode_sched.sv
// Decode-stage issue scheduler: per-register writeback scoreboard, hazard stall and HALT drain.
// Optional feature macro: DECODE_SCHED_FWD_EN (forwarding-aware busy window).
module decode_sched
  import decode_sched_pkg::*;
#(
  parameter int ALU_LAT = ALU_LAT_DEF,
  parameter int LD_LAT  = LD_LAT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [2:0] id_rs,
  input  logic [2:0] id_rt,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic [2:0] id_rd,
  input  logic       id_rd_wen,
  input  logic       id_is_load,
  input  logic       id_halt,
  input  logic       flush,
  output logic       stall,
  output logic       issue,
  output logic       halted,
  output logic [7:0] pending
);

  state_t             state;
  state_t             state_nxt;
  cnt_t               cnt [NREGS];
  logic [NREGS-1:0]   busy;
  logic [NREGS-1:0]   ld;
  cnt_t               new_lat;
  logic               hazard;

  assign new_lat = id_is_load ? cnt_t'(LD_LAT) : cnt_t'(ALU_LAT);

  // WAW check keeps an older, longer-latency writer from retiring after a younger one.
  assign hazard = (id_rs_used & busy[id_rs])
                | (id_rt_used & busy[id_rt])
                | (id_rd_wen & (cnt[id_rd] > new_lat));

  assign stall = id_valid & ~flush & (hazard | (state != RUN));
  assign issue = id_valid & ~flush & ~hazard & (state == RUN);

  always_comb begin
    ld = '0;
    if (issue && id_rd_wen) begin
      ld[id_rd] = 1'b1;
    end
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_ent
    sb_entry u_ent (
      .clk        (clk),
      .rst        (rst),
      .ld         (ld[i]),
      .ld_val     (new_lat),
      .ld_is_load (id_is_load),
      .cnt        (cnt[i]),
      .busy       (busy[i])
    );
    assign pending[i] = (cnt[i] != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (issue && id_halt) state_nxt = DRAIN;
      DRAIN:   if (pending == '0) state_nxt = HALT;
      HALT:    state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  assign halted = (state == HALT);

endmodule

// File: tb/tb_decode_sched.sv
// Scoreboard bench for decode_sched: directed per-cycle vectors queued by the driver, checked by a negedge monitor.
module tb_decode_sched;

`ifdef DECODE_SCHED_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  // Reader stall cycles behind an ALU writer and behind a load writer.
  localparam int SA = FWD ? 1 : 3;
  localparam int SL = FWD ? 3 : 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [2:0] id_rs = '0;
  logic [2:0] id_rt = '0;
  logic       id_rs_used = 1'b0;
  logic       id_rt_used = 1'b0;
  logic [2:0] id_rd = '0;
  logic       id_rd_wen = 1'b0;
  logic       id_is_load = 1'b0;
  logic       id_halt = 1'b0;
  logic       flush = 1'b0;
  logic       stall;
  logic       issue;
  logic       halted;
  logic [7:0] pending;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      nm;
    logic       s;
    logic       i;
    logic [7:0] p;
    logic       h;
  } exp_t;

  exp_t sbq[$];

  decode_sched dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_used (id_rs_used),
    .id_rt_used (id_rt_used),
    .id_rd      (id_rd),
    .id_rd_wen  (id_rd_wen),
    .id_is_load (id_is_load),
    .id_halt    (id_halt),
    .flush      (flush),
    .stall      (stall),
    .issue      (issue),
    .halted     (halted),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      if ({stall, issue, pending, halted} !== {e.s, e.i, e.p, e.h}) begin
        failures++;
        $display("FAIL %s: got stall=%0b issue=%0b pending=%02h halted=%0b want stall=%0b issue=%0b pending=%02h halted=%0b",
                 e.nm, stall, issue, pending, halted, e.s, e.i, e.p, e.h);
      end
    end
  end

  task automatic direct(input string nm, input logic [10:0] got, input logic [10:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %03h want %03h", nm, got, want);
    end
  endtask

  task automatic step(input string nm, input logic v,
                      input logic [2:0] rs, input logic rsu,
                      input logic [2:0] rt, input logic rtu,
                      input logic [2:0] rd, input logic wen, input logic ld,
                      input logic hlt, input logic fl,
                      input logic es, input logic ei, input logic [7:0] ep, input logic eh);
    exp_t e;
    @(posedge clk);
    #1;
    id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_rd = rd; id_rd_wen = wen; id_is_load = ld; id_halt = hlt; flush = fl;
    e.nm = nm; e.s = es; e.i = ei; e.p = ep; e.h = eh;
    sbq.push_back(e);
  endtask

  task automatic idle(input string nm, input logic [7:0] ep, input logic eh);
    step(nm, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ep, eh);
  endtask

  initial begin
    #3;
    direct("reset_outputs", {stall, issue, halted, pending}, 11'h000);
    @(negedge clk);
    rst = 1'b0;

    // ALU writer r3 then dependent reader
    step("alu_w_r3", 1, 0, 0, 0, 0, 3'd3, 1, 0, 0, 0, 0, 1, 8'h00, 0);
    for (int k = 0; k < SA; k++)
      step("alu_raw_stall", 1, 3'd3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h08, 0);
    step("alu_raw_issue", 1, 3'd3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, (3 - SA > 0) ? 8'h08 : 8'h00, 0);
    for (int j = 0; j < 2; j++)
      idle("alu_drain", (3 - SA - 1 - j > 0) ? 8'h08 : 8'h00, 0);

    // Load r5 then reader on rt
    step("ld_w_r5", 1, 0, 0, 0, 0, 3'd5, 1, 1, 0, 0, 0, 1, 8'h00, 0);
    for (int k = 0; k < SL; k++)
      step("ld_raw_stall", 1, 0, 0, 3'd5, 1, 0, 0, 0, 0, 0, 1, 0, 8'h20, 0);
    step("ld_raw_issue", 1, 0, 0, 3'd5, 1, 0, 0, 0, 0, 0, 0, 1, (4 - SL > 0) ? 8'h20 : 8'h00, 0);
    for (int j = 0; j < 2; j++)
      idle("ld_drain", (4 - SL - 1 - j > 0) ? 8'h20 : 8'h00, 0);

    // Unused source field names a pending register: no stall
    step("alu_w_r6", 1, 0, 0, 0, 0, 3'd6, 1, 0, 0, 0, 0, 1, 8'h00, 0);
    step("rs_unused", 1, 3'd6, 0, 3'd0, 1, 0, 0, 0, 0, 0, 0, 1, 8'h40, 0);
    idle("r6_cnt2", 8'h40, 0);
    idle("r6_cnt1", 8'h40, 0);
    idle("r6_cnt0", 8'h00, 0);

    // WAW: ALU write behind a longer load to the same register
    step("waw_ld_r1", 1, 0, 0, 0, 0, 3'd1, 1, 1, 0, 0, 0, 1, 8'h00, 0);
    step("waw_stall", 1, 0, 0, 0, 0, 3'd1, 1, 0, 0, 0, 1, 0, 8'h02, 0);
    step("waw_issue", 1, 0, 0, 0, 0, 3'd1, 1, 0, 0, 0, 0, 1, 8'h02, 0);
    idle("waw_cnt3", 8'h02, 0);
    idle("waw_cnt2", 8'h02, 0);
    idle("waw_cnt1", 8'h02, 0);
    idle("waw_cnt0", 8'h00, 0);

    // Register 0 is a real register
    step("alu_w_r0", 1, 0, 0, 0, 0, 3'd0, 1, 0, 0, 0, 0, 1, 8'h00, 0);
    step("r0_raw_stall", 1, 3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h01, 0);
    idle("r0_cnt2", 8'h01, 0);
    idle("r0_cnt1", 8'h01, 0);
    idle("r0_cnt0", 8'h00, 0);

    // Flush squashes issue and scoreboard load
    step("flush_w_r2", 1, 0, 0, 0, 0, 3'd2, 1, 0, 0, 1, 0, 0, 8'h00, 0);
    idle("flush_no_pend", 8'h00, 0);

    // HALT with a hazard must stall and not enter DRAIN
    step("alu_w_r4", 1, 0, 0, 0, 0, 3'd4, 1, 0, 0, 0, 0, 1, 8'h00, 0);
    step("halt_hazard", 1, 3'd4, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 8'h10, 0);
    idle("r4_cnt2", 8'h10, 0);
    idle("r4_cnt1", 8'h10, 0);
    idle("r4_cnt0", 8'h00, 0);
    step("still_run", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h00, 0);

    // Load r1 then HALT: drain until r1 retires, then halt
    step("halt_ld_r1", 1, 0, 0, 0, 0, 3'd1, 1, 1, 0, 0, 0, 1, 8'h00, 0);
    step("halt_issue", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 8'h02, 0);
    step("drain_c3", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h02, 0);
    step("drain_c2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h02, 0);
    step("drain_c1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h02, 0);
    step("drain_c0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h00, 0);
    step("halted", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h00, 1);
    step("halted_hold", 1, 0, 0, 0, 0, 3'd7, 1, 0, 0, 0, 1, 0, 8'h00, 1);
    idle("halted_idle", 8'h00, 1);

    // Async reset mid-DRAIN with r1/r2 outstanding
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    step("rd_alu_r1", 1, 0, 0, 0, 0, 3'd1, 1, 0, 0, 0, 0, 1, 8'h00, 0);
    step("rd_alu_r2", 1, 0, 0, 0, 0, 3'd2, 1, 0, 0, 0, 0, 1, 8'h02, 0);
    step("rd_halt", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 8'h06, 0);
    step("rd_draining", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h06, 0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    direct("async_rst_clear", {stall, issue, halted, pending}, {1'b0, 1'b1, 1'b0, 8'h00});
    #1;
    rst = 1'b0;
    id_valid = 1'b0;
    idle("post_rst_idle", 8'h00, 0);

    for (int w = 0; w < 10 && sbq.size() > 0; w++) @(negedge clk);
    #1;
    if (sbq.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d queued want 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
